// File: rtl/io_input_port_sel_if.sv
// rtl/io_input_port_sel_if.sv - input-port window bus: port data and load address in, read data out
interface io_input_port_sel_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] a1;
  logic [5:0]        addr;
  logic [DATA_W-1:0] y;
  logic              hit;
  logic [DATA_W-1:0] y_q;
  logic              hit_q;
  logic              sel_q;

  modport master (
    output a0, a1, addr,
    input  y, hit, y_q, hit_q, sel_q
  );

  modport slave (
    input  a0, a1, addr,
    output y, hit, y_q, hit_q, sel_q
  );
endinterface

// File: rtl/io_input_port_sel.sv
// rtl/io_input_port_sel.sv - input-port read-data selector with registered debug copies
module io_input_port_sel #(
  parameter int                DATA_W    = 32,
  parameter logic [5:0]        SEL0      = 6'b110000,
  parameter logic [5:0]        SEL1      = 6'b110001,
  parameter logic [DATA_W-1:0] DEFAULT_Y = '0
) (
  input  logic                 io_clk,
  input  logic                 reset,
  io_input_port_sel_if.slave   bus
);

  logic [DATA_W-1:0] y_c;
  logic              hit_c;
  logic              hit0_c;
  logic              hit1_c;

  // SEL0 is tested first so a misconfigured SEL0==SEL1 resolves to port 0
  always_comb begin
    y_c    = DEFAULT_Y;
    hit_c  = 1'b0;
    hit0_c = 1'b0;
    hit1_c = 1'b0;
    if (bus.addr == SEL0) begin
      y_c    = bus.a0;
      hit_c  = 1'b1;
      hit0_c = 1'b1;
    end else if (bus.addr == SEL1) begin
      y_c    = bus.a1;
      hit_c  = 1'b1;
      hit1_c = 1'b1;
    end
  end

  assign bus.y   = y_c;
  assign bus.hit = hit_c;

  always_ff @(posedge io_clk) begin
    if (reset) begin
      bus.y_q   <= '0;
      bus.hit_q <= 1'b0;
      bus.sel_q <= 1'b0;
    end else begin
      bus.y_q   <= y_c;
      bus.hit_q <= hit_c;
      if (hit0_c) begin
        bus.sel_q <= 1'b0;
      end else if (hit1_c) begin
        bus.sel_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_input_port_sel.sv
// tb/tb_io_input_port_sel.sv - directed-vector bench for io_input_port_sel
module tb_io_input_port_sel;

  logic io_clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  io_input_port_sel_if #(.DATA_W(32)) bus ();

  io_input_port_sel dut (
    .io_clk (io_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 io_clk = ~io_clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  logic [31:0] exp_y;
  logic        exp_hit;
  logic        exp_sel;

  initial begin
    reset    = 1'b1;
    bus.a0   = 32'h0000_0015;
    bus.a1   = 32'h0000_000A;
    bus.addr = 6'b000000;
    tick();
    check_vec("rst_y_q",   bus.y_q,   32'h0);
    check_vec("rst_hit_q", {31'h0, bus.hit_q}, 32'h0);
    check_vec("rst_sel_q", {31'h0, bus.sel_q}, 32'h0);
    reset = 1'b0;

    bus.addr = 6'b110000;
    #1;
    check_vec("p0_y",   bus.y, 32'h15);
    check_vec("p0_hit", {31'h0, bus.hit}, 32'h1);
    tick();
    check_vec("p0_y_q",   bus.y_q, 32'h15);
    check_vec("p0_hit_q", {31'h0, bus.hit_q}, 32'h1);
    check_vec("p0_sel_q", {31'h0, bus.sel_q}, 32'h0);

    bus.addr = 6'b110001;
    #1;
    check_vec("p1_y",   bus.y, 32'h0A);
    check_vec("p1_hit", {31'h0, bus.hit}, 32'h1);
    tick();
    check_vec("p1_y_q",   bus.y_q, 32'h0A);
    check_vec("p1_sel_q", {31'h0, bus.sel_q}, 32'h1);

    bus.addr = 6'b000000;
    #1;
    check_vec("miss00_y",   bus.y, 32'h0);
    check_vec("miss00_hit", {31'h0, bus.hit}, 32'h0);
    tick();
    check_vec("miss00_y_q",   bus.y_q, 32'h0);
    check_vec("miss00_hit_q", {31'h0, bus.hit_q}, 32'h0);
    check_vec("miss00_sel_q", {31'h0, bus.sel_q}, 32'h1);

    bus.addr = 6'b111111;
    #1;
    check_vec("miss3f_y",   bus.y, 32'h0);
    check_vec("miss3f_hit", {31'h0, bus.hit}, 32'h0);
    tick();
    check_vec("miss3f_y_q",   bus.y_q, 32'h0);
    check_vec("miss3f_hit_q", {31'h0, bus.hit_q}, 32'h0);
    check_vec("miss3f_sel_q", {31'h0, bus.sel_q}, 32'h1);

    // full address sweep; sel model carries over the previous hit index
    bus.a0  = 32'hDEAD_BEEF;
    bus.a1  = 32'h1234_5678;
    exp_sel = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.addr = 6'(i);
      exp_y    = (i == 48) ? 32'hDEAD_BEEF : (i == 49) ? 32'h1234_5678 : 32'h0;
      exp_hit  = (i == 48) || (i == 49);
      if (i == 48) exp_sel = 1'b0;
      if (i == 49) exp_sel = 1'b1;
      #1;
      check_vec($sformatf("sweep%0d_y", i),   bus.y, exp_y);
      check_vec($sformatf("sweep%0d_hit", i), {31'h0, bus.hit}, {31'h0, exp_hit});
      tick();
      check_vec($sformatf("sweep%0d_y_q", i),   bus.y_q, exp_y);
      check_vec($sformatf("sweep%0d_hit_q", i), {31'h0, bus.hit_q}, {31'h0, exp_hit});
      check_vec($sformatf("sweep%0d_sel_q", i), {31'h0, bus.sel_q}, {31'h0, exp_sel});
    end

    bus.addr = 6'b110000;
    bus.a0   = 32'h0000_0015;
    tick();
    check_vec("chg_y_q_before", bus.y_q, 32'h15);
    bus.a0 = 32'hCAFE_F00D;
    #1;
    check_vec("chg_y_comb", bus.y,   32'hCAFE_F00D);
    check_vec("chg_y_q_hold", bus.y_q, 32'h15);
    tick();
    check_vec("chg_y_q_after", bus.y_q, 32'hCAFE_F00D);

    bus.addr = 6'b110001;
    bus.a1   = 32'h0000_000A;
    reset    = 1'b1;
    tick();
    check_vec("mrst_y_q",   bus.y_q, 32'h0);
    check_vec("mrst_hit_q", {31'h0, bus.hit_q}, 32'h0);
    check_vec("mrst_sel_q", {31'h0, bus.sel_q}, 32'h0);
    check_vec("mrst_y",     bus.y, 32'h0A);
    check_vec("mrst_hit",   {31'h0, bus.hit}, 32'h1);
    reset = 1'b0;
    tick();
    check_vec("post_y_q",   bus.y_q, 32'h0A);
    check_vec("post_hit_q", {31'h0, bus.hit_q}, 32'h1);
    check_vec("post_sel_q", {31'h0, bus.sel_q}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_input_port_sel.md
Name: io_input_port_sel

Overview:
- Read-data selector for the memory-mapped input-port window of the single-cycle CPU with I/O.
- Decodes word-address bits [7:2] of a load address and picks one of two 32-bit input-port registers.
- Drives the combinational result onto the I/O read-data bus.
- Also provides registered copies of the read data and the decode result, for debug and for pipelined consumers.

Parameters:
- DATA_W, 32, width of port data and read data.
- SEL0, 6'b110000, word-select code of port 0 (byte address 0xC0).
- SEL1, 6'b110001, word-select code of port 1 (byte address 0xC4).
- DEFAULT_Y, 0, value driven on y when no port is selected.

Ports:
- io_clk  input  1  I/O clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high reset.
- a0  input  DATA_W  input port register 0 contents.
- a1  input  DATA_W  input port register 1 contents.
- addr  input  6  word-select field (load address bits [7:2]).
- y  output  DATA_W  combinational selected read data.
- hit  output  1  combinational; 1 when addr matches SEL0 or SEL1.
- y_q  output  DATA_W  y registered on io_clk.
- hit_q  output  1  hit registered on io_clk.
- sel_q  output  1  index of the last port hit (0 or 1), registered.

Behaviour:
- Interface: one clock (io_clk); reset is synchronous and active-high.
- Combinational path, no latency:
  - addr==SEL0: y=a0, hit=1.
  - addr==SEL1: y=a1, hit=1.
  - any other addr: y=DEFAULT_Y, hit=0.
- No latches: every addr value yields a defined y.
- If SEL0==SEL1 (misconfiguration), port 0 has priority.
- y and hit are not affected by reset or io_clk. The CPU reads y in the same cycle.
- Registered path, on each rising edge of io_clk:
  - reset=1: y_q<=0, hit_q<=0, sel_q<=0.
  - otherwise: y_q<=y, hit_q<=hit.
  - sel_q<=0 on a SEL0 hit, <=1 on a SEL1 hit, otherwise unchanged.
- Latency of the registered outputs: exactly 1 io_clk cycle after addr/a0/a1 settle.
- Reset asserted mid-stream clears all registered outputs on that edge. The combinational y keeps tracking its inputs.
- Data passes through unmodified: no masking, sign extension or truncation of a0/a1.

Test Plan:
- addr=6'b110000, a0=32'h0000_0015, a1=32'h0000_000A -> y=32'h15, hit=1; after one io_clk edge y_q=32'h15, hit_q=1, sel_q=0.
- addr=6'b110001, same data -> y=32'h0A, hit=1; next edge y_q=32'h0A, sel_q=1.
- addr=6'b000000 and addr=6'b111111 -> y=0, hit=0; next edge hit_q=0, y_q=0, sel_q holds its previous value.
- Sweep all 64 addr values with a0=32'hDEAD_BEEF, a1=32'h1234_5678 -> only 0x30 and 0x31 hit, with the correct data; every other code gives 0.
- Change a0 while addr=SEL0 -> y follows within the same cycle (combinational); y_q updates on the next edge only.
- Assert reset for one edge with addr=SEL1 -> y_q=0, hit_q=0, sel_q=0 after the edge while y still equals a1; deassert -> next edge y_q=a1, hit_q=1, sel_q=1.
